// File: rtl/pet_pkg.sv
// pet_pkg: shared mode/hold encodings, default tick constants and counter sizing
package pet_pkg;
  typedef enum logic [1:0] {HEALTHY = 2'd0, SICK = 2'd1, DEAD = 2'd2} mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FIRED = 2'd2} hold_t;
  localparam int unsigned DEF_HOLD_TICKS  = 125_000_000;
  localparam int unsigned DEF_DECAY_TICKS = 750_000_000;
  localparam int unsigned DEF_SICK_TICKS  = 1_500_000_000;
  function automatic int cnt_w(input int unsigned ticks);
    return ticks > 1 ? $clog2(ticks) : 1;
  endfunction
endpackage

// File: rtl/pet_hold_detect.sv
// pet_hold_detect: one channel's button synchronizer and press-and-hold detector
module pet_hold_detect
  import pet_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic kill,
  output logic fire
);
  localparam int CW = cnt_w(HOLD_TICKS);
  localparam logic [CW-1:0] LAST = CW'(HOLD_TICKS - 1);
  logic [1:0] sync;
  hold_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], btn};
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fire     = 1'b0;
    if (kill) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else
      case (state)
        IDLE: if (sync[1]) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end
        HOLD: if (!sync[1]) state_nx = IDLE;
        else if (cnt == LAST) begin
          state_nx = FIRED;
          fire     = 1'b1;
        end else cnt_nx = cnt + CW'(1);
        FIRED: if (!sync[1]) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
  end
endmodule

// File: rtl/pet_needs_ctrl.sv
// pet_needs_ctrl: press-and-hold need channels with decaying levels and pet health mode
module pet_needs_ctrl
  import pet_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int LVL_W = 2,
  parameter int unsigned HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int unsigned DECAY_TICKS = DEF_DECAY_TICKS,
  parameter int unsigned SICK_TICKS  = DEF_SICK_TICKS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         btn,
  output logic [N_CH*LVL_W-1:0]   level,
  output logic [N_CH-1:0]         active,
  output logic [1:0]              mode
);
  localparam int DW = cnt_w(DECAY_TICKS);
  localparam int SW = cnt_w(SICK_TICKS);
  localparam logic [LVL_W-1:0] LVL_MAX = '1;
  localparam logic [DW-1:0] D_LAST = DW'(DECAY_TICKS - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SICK_TICKS - 1);
  mode_t mode_q, mode_nx;
  logic [SW-1:0] sick_cnt, sick_nx;
  logic [N_CH-1:0] zero;
  logic dead;
  assign dead = mode_q == DEAD;
  assign mode = mode_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [LVL_W-1:0] lvl;
    logic [DW-1:0] dcnt;
    logic wrap;
    pet_hold_detect #(.HOLD_TICKS(HOLD_TICKS)) u_hold (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[i]),
      .kill (dead),
      .fire (active[i])
    );
    assign wrap = dcnt == D_LAST;
    assign zero[i] = lvl == '0;
    assign level[i*LVL_W +: LVL_W] = lvl;
    // a press and a decay in the same cycle cancel; a press always restarts decay
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        lvl  <= LVL_MAX;
        dcnt <= '0;
      end else if (!dead) begin
        dcnt <= (active[i] || wrap) ? '0 : dcnt + DW'(1);
        lvl  <= (active[i] && !wrap && lvl != LVL_MAX) ? lvl + LVL_W'(1) :
                (wrap && !active[i] && lvl != '0) ? lvl - LVL_W'(1) : lvl;
      end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mode_q   <= HEALTHY;
      sick_cnt <= '0;
    end else begin
      mode_q   <= mode_nx;
      sick_cnt <= sick_nx;
    end
  always_comb begin
    mode_nx = mode_q;
    sick_nx = sick_cnt;
    case (mode_q)
      HEALTHY: if (|zero) begin
        mode_nx = SICK;
        sick_nx = '0;
      end
      SICK: if (!(|zero)) mode_nx = HEALTHY;
      else if (sick_cnt == S_LAST) mode_nx = DEAD;
      else sick_nx = sick_cnt + SW'(1);
      default: mode_nx = DEAD;
    endcase
  end
endmodule

// File: tb/tb_pet_needs_ctrl.sv
// tb_pet_needs_ctrl: directed and random checks of pet_needs_ctrl against a cycle model
module tb_pet_needs_ctrl;
  localparam int N = 2, W = 2, H = 4, D = 20, S = 10, LMAX = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N*W-1:0] level;
  logic [N-1:0] active;
  logic [1:0] mode;
  int errs = 0, checks = 0;
  int m_lvl[N], m_dc[N], m_run[N], pulses[N];
  int m_mode, m_sc;
  bit m_pulse[N];
  logic [N-1:0] m_s1, m_s2;

  always #5 clk = ~clk;

  pet_needs_ctrl #(.N_CH(N), .LVL_W(W), .HOLD_TICKS(H), .DECAY_TICKS(D), .SICK_TICKS(S)) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .level (level),
    .active(active),
    .mode  (mode)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] mlev();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_lvl[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] mact();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pulse[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = LMAX; m_dc[i] = 0; m_run[i] = 0; m_pulse[i] = 0;
    end
    m_s1 = '0; m_s2 = '0; m_mode = 0; m_sc = 0;
  endtask

  // one rising edge: levels react to last cycle's pulses, mode to last cycle's levels
  task automatic model_edge();
    bit any0;
    bit wrap;
    any0 = 0;
    for (int i = 0; i < N; i++) if (m_lvl[i] == 0) any0 = 1;
    if (m_mode != 2)
      for (int i = 0; i < N; i++) begin
        wrap = m_dc[i] == D - 1;
        if (m_pulse[i] && !wrap) m_lvl[i] = m_lvl[i] < LMAX ? m_lvl[i] + 1 : LMAX;
        if (wrap && !m_pulse[i]) m_lvl[i] = m_lvl[i] > 0 ? m_lvl[i] - 1 : 0;
        m_dc[i] = (m_pulse[i] || wrap) ? 0 : m_dc[i] + 1;
      end
    if (m_mode == 0 && any0) begin
      m_mode = 1; m_sc = 0;
    end else if (m_mode == 1) begin
      if (!any0) m_mode = 0;
      else begin
        m_sc++;
        if (m_sc == S) m_mode = 2;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
    for (int i = 0; i < N; i++) begin
      m_run[i] = m_s2[i] ? m_run[i] + 1 : 0;
      m_pulse[i] = (m_mode != 2) && (m_run[i] == H + 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset(); else model_edge();
    #1;
    for (int i = 0; i < N; i++) if (active[i]) pulses[i]++;
    chk("level", level, mlev());
    chk("active", active, mact());
    chk("mode", mode, m_mode);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic reset_cycle();
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int p0, p1, dl, dead_cnt, idx;
    logic [N*W-1:0] frozen;
    model_reset();
    for (int i = 0; i < N; i++) pulses[i] = 0;
    ticks(2);
    chk("rst_level", level, 4'hF);
    chk("rst_mode", mode, 0);
    chk("rst_active", active, 0);
    reset = 1'b1;
    ticks(19);
    chk("pre_decay", level, 4'hF);
    tick();
    chk("decay_wrap", level, 4'hA);
    chk("decay_mode", mode, 0);

    p0 = pulses[0];
    btn = 2'b01;
    ticks(3);
    btn = 2'b00;
    ticks(5);
    chk("short_hold_pulses", pulses[0] - p0, 0);
    chk("short_hold_lvl0", level[1:0], 2);
    btn = 2'b01;
    ticks(10);
    chk("hold_pulses", pulses[0] - p0, 1);
    chk("hold_lvl0", level[1:0], 3);
    btn = 2'b00;
    ticks(3);
    btn = 2'b01;
    ticks(10);
    chk("sat_pulses", pulses[0] - p0, 2);
    chk("sat_lvl0", level[1:0], 3);
    btn = 2'b00;

    reset_cycle();
    ticks(55);
    btn = 2'b10;
    ticks(3);
    btn = 2'b11;
    ticks(2);
    chk("drained", level, 4'h0);
    tick();
    chk("sick_entry", mode, 1);
    ticks(2);
    chk("one_raised_lvl", level, 4'b0100);
    chk("one_raised_mode", mode, 1);
    ticks(3);
    chk("recovered_mode", mode, 0);
    chk("recovered_lvl", level, 4'b0101);
    btn = 2'b00;

    dl = 0;
    while (mode !== 2'd2 && dl < 300) begin
      tick();
      dl++;
    end
    chk("dead_reached", mode, 2);
    frozen = mlev();
    p0 = pulses[0];
    p1 = pulses[1];
    btn = 2'b11;
    ticks(15);
    chk("dead_pulses0", pulses[0] - p0, 0);
    chk("dead_pulses1", pulses[1] - p1, 0);
    chk("dead_frozen", level, frozen);
    chk("dead_stays", mode, 2);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_level", level, 4'hF);
    chk("async_rst_mode", mode, 0);
    btn = 2'b00;
    tick();
    reset = 1'b1;

    ticks(13);
    btn = 2'b01;
    ticks(6);
    chk("wrap_press_active", active, 2'b01);
    tick();
    chk("wrap_press_level", level, 4'b1011);
    ticks(19);
    chk("restart_hold", level, 4'b1011);
    tick();
    chk("restart_decay", level, 4'b0110);
    btn = 2'b00;

    reset_cycle();
    btn = 2'b01;
    ticks(4);
    p0 = pulses[0];
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("abort_active", active, 0);
    chk("abort_level", level, 4'hF);
    ticks(2);
    reset = 1'b1;
    ticks(5);
    chk("rehold_early", pulses[0] - p0, 0);
    tick();
    chk("rehold_fire", active, 2'b01);
    chk("rehold_count", pulses[0] - p0, 1);
    btn = 2'b00;

    reset_cycle();
    dead_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        idx = $urandom_range(N - 1);
        btn[idx] = ~btn[idx];
      end
      tick();
      if (m_mode == 2) dead_cnt++;
      if (dead_cnt > 15) begin
        reset_cycle();
        dead_cnt = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pet_needs_ctrl.md
PET_NEEDS_CTRL -- requirements
Module: pet_needs_ctrl

Interface
REQ-001 Parameter N_CH, default 2; number of need channels (food, medicine, ...), range 1..8.
REQ-002 Parameter LVL_W, default 2; level width, LVL_MAX = 2^LVL_W-1.
REQ-003 Parameter HOLD_TICKS, default 125_000_000; button-hold cycles required to register a press (5 s @ 25 MHz).
REQ-004 Parameter DECAY_TICKS, default 750_000_000; cycles between level decrements per channel.
REQ-005 Parameter SICK_TICKS, default 1_500_000_000; cycles in SICK before DEAD.
REQ-006 clk  input  1  single system clock, all logic rising-edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 btn  input  N_CH  raw asynchronous buttons, active-high, bit i = channel i.
REQ-009 level  output  N_CH*LVL_W  packed levels, channel i at [i*LVL_W +: LVL_W].
REQ-010 active  output  N_CH  one-cycle pulse per channel when a press registers.
REQ-011 mode  output  2  pet mode: 0 HEALTHY, 1 SICK, 2 DEAD.

Function
REQ-012 Each btn bit SHALL pass a 2-flop synchronizer; press logic uses only synchronized values (2-cycle input latency).
REQ-013 Per-channel hold FSM SHALL have states IDLE, HOLD, FIRED.
REQ-014 IDLE->HOLD on sync btn=1, hold counter cleared; HOLD->IDLE on btn=0 with no pulse.
REQ-015 HOLD->FIRED when counter reaches HOLD_TICKS-1 with btn still 1; active[i] pulses exactly that cycle.
REQ-016 FIRED->IDLE only on btn=0; no further pulse while held.
REQ-017 On active[i], level[i] SHALL increment by 1, saturating at LVL_MAX (pulse still issued at LVL_MAX).
REQ-018 Per-channel decay counter SHALL wrap at DECAY_TICKS-1 and then decrement level[i], saturating at 0.
REQ-019 A press registering restarts that channel's decay counter.
REQ-020 Increment and decay in the same cycle: level unchanged.
REQ-021 mode: HEALTHY->SICK when any level = 0; SICK->HEALTHY when all levels > 0; SICK counter cleared on entry.
REQ-022 SICK->DEAD after SICK_TICKS consecutive cycles in SICK.
REQ-023 DEAD is terminal until reset: levels frozen, active held 0, hold FSMs forced IDLE.
REQ-024 Level updates visible on level output the cycle after active pulse (registered output).
REQ-025 Simultaneous presses on multiple channels SHALL be handled independently, same cycle.

Reset
REQ-026 While reset=0: all levels = LVL_MAX, active = 0, mode = HEALTHY, hold FSMs IDLE, all counters and synchronizers 0.
REQ-027 Reset mid-hold SHALL abort the hold with no pulse; after release of reset a still-held button needs a full HOLD_TICKS again.
REQ-028 Reset release synchronization is outside this block; reset assertion takes effect immediately.

Structure
REQ-029 Package pet_pkg SHALL hold the mode encoding (HEALTHY/SICK/DEAD), hold-FSM state typedef and default tick constants.
REQ-030 Sub-module pet_hold_detect SHALL implement one channel's synchronizer + hold FSM + counter, instantiated N_CH times via generate.
REQ-031 Counter widths SHALL be $clog2 of the respective tick parameter.

Verification (bench: N_CH=2, LVL_W=2, HOLD_TICKS=4, DECAY_TICKS=20, SICK_TICKS=10)
REQ-032 Reset, then btn=00 for 19 cycles -> level=1111, mode=0; at decay wrap both levels become 2 (level=1010).
REQ-033 btn[0] high 3 synchronized cycles then low -> no active pulse, level[0] unchanged; held 10 cycles -> exactly one active[0] pulse, level[0] saturates at 3.
REQ-034 Drain both to 0 via decay -> mode=1 at first zero; hold btn[1] to raise level[1] while level[0]=0 -> mode stays 1; raise level[0] before 10 cycles -> mode=0.
REQ-035 Leave a level at 0 for 10 cycles -> mode=2; further presses -> no pulses, levels frozen; reset=0 -> levels=3, mode=0.
REQ-036 Press registering on the exact decay-wrap cycle -> level unchanged that cycle, decay counter restarts.
REQ-037 Assert reset during cycle 3 of a hold, release with btn still high -> pulse only after 4 further synchronized high cycles.
